wasca_onchip_ram_2p: RTL and testbench

- Parametrised true dual-port on-chip RAM with two independent Avalon-MM slaves, s1 and s2, and pipelined reads.
- Successor to the fixed 32-bit single-port 6144-word block.
- Adds configurable width, depth and read latency, readdatavalid and waitrequest handshakes, out-of-range address handling and defined same-cycle collision rules.
- Sits on the Nios/SCSP bridge fabric as a shared buffer between the CPU and the Saturn-side bus logic.

---
 rtl/wasca_onchip_ram_2p_if.sv | 30 +++
 rtl/wasca_onchip_ram_2p.sv | 122 ++++++++++++
 tb/tb_wasca_onchip_ram_2p.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wasca_onchip_ram_2p_if.sv
// Avalon-MM slave bundle for one port of the dual-port on-chip RAM.
// Master drives the request side, slave returns data and handshakes.
interface wasca_onchip_ram_2p_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] address;
    logic [BE_WIDTH-1:0]   byteenable;
    logic                  chipselect;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  readdatavalid;
    logic                  waitrequest;

    modport master (
        output address, byteenable, chipselect,
        output read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, byteenable, chipselect,
        input  read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/wasca_onchip_ram_2p.sv
// True dual-port on-chip RAM, two Avalon-MM slaves, pipelined reads.
// Shared buffer between the Nios side and the Saturn-side bus logic.
module wasca_onchip_ram_2p #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 6144,
    parameter int ADDR_WIDTH   = 13,
    parameter int READ_LATENCY = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clken,
    input  logic reset_req,
    wasca_onchip_ram_2p_if.slave s1,
    wasca_onchip_ram_2p_if.slave s2
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  rdy_q;
    logic                  stall;
    logic [ADDR_WIDTH-1:0] addr  [2];
    logic [BE_WIDTH-1:0]   be    [2];
    logic [DATA_WIDTH-1:0] wdata [2];
    logic [DATA_WIDTH-1:0] rdata [2];
    logic [1:0]            cs;
    logic [1:0]            rd;
    logic [1:0]            wr;
    logic [1:0]            in_rng;
    logic [1:0]            acc_rd;
    logic [1:0]            acc_wr;
    logic [1:0]            rvalid;

    assign addr[0]  = s1.address;
    assign addr[1]  = s2.address;
    assign be[0]    = s1.byteenable;
    assign be[1]    = s2.byteenable;
    assign wdata[0] = s1.writedata;
    assign wdata[1] = s2.writedata;
    assign cs       = {s2.chipselect, s1.chipselect};
    assign rd       = {s2.read, s1.read};
    assign wr       = {s2.write, s1.write};

    assign s1.readdata      = rdata[0];
    assign s2.readdata      = rdata[1];
    assign s1.readdatavalid = rvalid[0];
    assign s2.readdatavalid = rvalid[1];
    assign s1.waitrequest   = stall;
    assign s2.waitrequest   = stall;

    // Held low through the release cycle so nothing is accepted on it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdy_q <= 1'b0;
        else          rdy_q <= 1'b1;
    end

    assign stall = ~clken | reset_req | ~reset_n | ~rdy_q;

    // s2 lanes first so s1 overrides on overlapping byte lanes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (acc_wr[1] && in_rng[1] && be[1][i])
                mem[addr[1]][i*8 +: 8] <= wdata[1][i*8 +: 8];
            if (acc_wr[0] && in_rng[0] && be[0][i])
                mem[addr[0]][i*8 +: 8] <= wdata[0][i*8 +: 8];
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic                  v1;
        logic                  z1;
        logic [DATA_WIDTH-1:0] d1;
        logic [DATA_WIDTH-1:0] q;

        assign in_rng[p] = (int'(addr[p]) < DEPTH);
        assign acc_wr[p] = ~stall & cs[p] & wr[p];
        assign acc_rd[p] = ~stall & cs[p] & rd[p] & ~wr[p];

        always_ff @(posedge clk) begin
            if (acc_rd[p] && in_rng[p])
                d1 <= mem[addr[p]];
        end

        // z1 marks an out-of-range read so the output is forced to zero.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                v1 <= 1'b0;
                z1 <= 1'b1;
            end else if (reset_req) begin
                v1 <= 1'b0;
            end else if (clken) begin
                v1 <= acc_rd[p];
                if (acc_rd[p])
                    z1 <= ~in_rng[p];
            end
        end

        if (READ_LATENCY == 2) begin : g_rl2
            logic                  v2;
            logic [DATA_WIDTH-1:0] d2;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)       v2 <= 1'b0;
                else if (reset_req) v2 <= 1'b0;
                else if (clken)     v2 <= v1;
            end

            always_ff @(posedge clk) begin
                if (clken && v1 && !reset_req)
                    d2 <= z1 ? '0 : d1;
            end

            assign q         = d2;
            assign rvalid[p] = v2 & clken;
        end else begin : g_rl1
            assign q         = z1 ? '0 : d1;
            assign rvalid[p] = v1 & clken;
        end

        assign rdata[p] = rdy_q ? q : '0;
    end
endmodule

// File: tb/tb_wasca_onchip_ram_2p.sv
// Scoreboard bench: DUT a uses read latency 1, DUT b latency 2.
// Stimulus pushes expected data and arrival cycle; monitor pops on valid.
module tb_wasca_onchip_ram_2p;
    localparam int AW = 13;

    logic clk = 1'b0;
    logic reset_n;
    logic clken;
    logic reset_req;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    wasca_onchip_ram_2p_if #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) a1 ();
    wasca_onchip_ram_2p_if #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) a2 ();
    wasca_onchip_ram_2p_if #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) b1 ();
    wasca_onchip_ram_2p_if #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) b2 ();

    wasca_onchip_ram_2p #(
        .DATA_WIDTH(32), .DEPTH(6144), .ADDR_WIDTH(AW), .READ_LATENCY(1)
    ) u_a (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .reset_req(reset_req), .s1(a1), .s2(a2)
    );

    wasca_onchip_ram_2p #(
        .DATA_WIDTH(32), .DEPTH(6144), .ADDR_WIDTH(AW), .READ_LATENCY(2)
    ) u_b (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .reset_req(reset_req), .s1(b1), .s2(b2)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic set_port(int id, logic r, logic w, logic [AW-1:0] a,
                            logic [31:0] d, logic [3:0] be);
        case (id)
            0: begin
                a1.chipselect = 1'b1; a1.read = r; a1.write = w;
                a1.address = a; a1.writedata = d; a1.byteenable = be;
            end
            1: begin
                a2.chipselect = 1'b1; a2.read = r; a2.write = w;
                a2.address = a; a2.writedata = d; a2.byteenable = be;
            end
            2: begin
                b1.chipselect = 1'b1; b1.read = r; b1.write = w;
                b1.address = a; b1.writedata = d; b1.byteenable = be;
            end
            default: begin
                b2.chipselect = 1'b1; b2.read = r; b2.write = w;
                b2.address = a; b2.writedata = d; b2.byteenable = be;
            end
        endcase
    endtask

    task automatic idle_all();
        a1.chipselect = 0; a1.read = 0; a1.write = 0;
        a2.chipselect = 0; a2.read = 0; a2.write = 0;
        b1.chipselect = 0; b1.read = 0; b1.write = 0;
        b2.chipselect = 0; b2.read = 0; b2.write = 0;
        a1.address = '0; a1.writedata = '0; a1.byteenable = '0;
        a2.address = '0; a2.writedata = '0; a2.byteenable = '0;
        b1.address = '0; b1.writedata = '0; b1.byteenable = '0;
        b2.address = '0; b2.writedata = '0; b2.byteenable = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle_all();
    endtask

    task automatic wr(int id, logic [AW-1:0] a, logic [31:0] d,
                      logic [3:0] be);
        set_port(id, 1'b0, 1'b1, a, d, be);
    endtask

    task automatic rd(int id, logic [AW-1:0] a, logic [31:0] exp, int extra);
        exp_t e;
        set_port(id, 1'b1, 1'b0, a, 32'h0, 4'hf);
        e.data = exp;
        e.cyc  = cyc + ((id < 2) ? 1 : 2) + extra;
        case (id)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic pop(int id, logic [31:0] act);
        exp_t e;
        bit   empty;
        empty = 1'b0;
        case (id)
            0: if (q0.size() == 0) empty = 1'b1; else e = q0.pop_front();
            1: if (q1.size() == 0) empty = 1'b1; else e = q1.pop_front();
            2: if (q2.size() == 0) empty = 1'b1; else e = q2.pop_front();
            default:
               if (q3.size() == 0) empty = 1'b1; else e = q3.pop_front();
        endcase
        if (empty) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected valid port%0d: got data %h at cycle %0d, required no valid",
                     id, act, cyc);
        end else begin
            chk($sformatf("rdata p%0d", id), act, e.data);
            chk($sformatf("valid cycle p%0d", id), cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (a1.readdatavalid === 1'b1) pop(0, a1.readdata);
        if (a2.readdatavalid === 1'b1) pop(1, a2.readdata);
        if (b1.readdatavalid === 1'b1) pop(2, b1.readdata);
        if (b2.readdatavalid === 1'b1) pop(3, b2.readdata);
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        clken     = 1'b1;
        reset_req = 1'b0;
        idle_all();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst rdata a1", a1.readdata, 32'h0);
        chk("rst valid a1", 32'(a1.readdatavalid), 32'h0);
        chk("rst wait a1", 32'(a1.waitrequest), 32'h1);
        chk("rst wait b2", 32'(b2.waitrequest), 32'h1);
        chk("rst rdata b1", b1.readdata, 32'h0);

        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("release wait a1", 32'(a1.waitrequest), 32'h1);
        chk("release rdata b1", b1.readdata, 32'h0);
        step();
        chk("run wait a1", 32'(a1.waitrequest), 32'h0);
        chk("run wait b2", 32'(b2.waitrequest), 32'h0);

        // basic write then read, latency 1
        wr(0, 5, 32'hDEADBEEF, 4'hf); step();
        rd(0, 5, 32'hDEADBEEF, 0);    step();

        // byte enables on s2
        wr(1, 7, 32'hAABBCCDD, 4'hf); step();
        wr(1, 7, 32'h11223344, 4'h5); step();
        rd(1, 7, 32'hAA22CC44, 0);    step();

        // same-word write collision, then mixed-port read of old data
        wr(0, 9, 32'hCAFEF00D, 4'hf); step();
        wr(0, 9, 32'h000000FF, 4'h1);
        wr(1, 9, 32'h12345678, 4'hf); step();
        rd(0, 9, 32'h123456FF, 0);    step();
        wr(0, 9, 32'hA5A5A5A5, 4'hf);
        rd(1, 9, 32'h123456FF, 0);    step();
        rd(1, 9, 32'hA5A5A5A5, 0);    step();

        // read and write together: the write wins, no valid
        set_port(0, 1'b1, 1'b1, 11, 32'h01020304, 4'hf); step();
        rd(0, 11, 32'h01020304, 0); step();

        // back-to-back reads at latency 2 on both ports
        for (int i = 0; i < 4; i++) begin
            wr(2, AW'(i), 32'h10000000 + 32'(i) * 32'h111, 4'hf);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            rd(2, AW'(i), 32'h10000000 + 32'(i) * 32'h111, 0);
            rd(3, AW'(3 - i), 32'h10000000 + 32'(3 - i) * 32'h111, 0);
            step();
        end
        repeat (3) step();

        // clken stall with a read in flight
        rd(0, 5, 32'hDEADBEEF, 3); step();
        clken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall wait a1", 32'(a1.waitrequest), 32'h1);
            chk("stall wait a2", 32'(a2.waitrequest), 32'h1);
            @(posedge clk);
            #1;
        end
        clken = 1'b1;
        repeat (2) step();

        // reset_req discards an in-flight read
        set_port(2, 1'b1, 1'b0, 1, 32'h0, 4'hf); step();
        reset_req = 1'b1;
        #1;
        chk("reset_req wait b1", 32'(b1.waitrequest), 32'h1);
        step();
        reset_req = 1'b0;
        repeat (3) step();
        rd(2, 2, 32'h10000222, 0); step();

        // out-of-range write and read
        wr(0, 56, 32'h56565656, 4'hf);   step();
        wr(0, 6200, 32'hBADC0FFE, 4'hf); step();
        rd(0, 6200, 32'h0, 0);           step();
        rd(0, 56, 32'h56565656, 0);      step();

        repeat (6) step();
        chk("drain q0", 32'(q0.size()), 32'h0);
        chk("drain q1", 32'(q1.size()), 32'h0);
        chk("drain q2", 32'(q2.size()), 32'h0);
        chk("drain q3", 32'(q3.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
